// File: rtl/expand_a_collector_pkg.sv
// Shared constants and FSM state encoding for the A-matrix expansion path.
package dilithium_pkg;
    localparam int N      = 256;
    localparam int Q      = 8380417;
    localparam int COEF_W = 24;
    localparam int K_DEF  = 4;
    localparam int L_DEF  = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_KICK,
        S_COLLECT,
        S_WAIT_DONE,
        S_NEXT,
        S_FIN
    } state_t;
endpackage

// File: rtl/expand_a_collector_if.sv
// Sampler handshake plus A-matrix RAM write port, seen from the collector.
interface expand_a_collector_if #(
    parameter int COEF_W = dilithium_pkg::COEF_W,
    parameter int ADDR_W = 12
);
    logic              start_rej;
    logic [255:0]      rho_out;
    logic [7:0]        i_out;
    logic [7:0]        j_out;
    logic              done_rej;
    logic [COEF_W-1:0] z_in;
    logic              z_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [COEF_W-1:0] wr_data;

    modport master (
        output start_rej, rho_out, i_out, j_out, wr_en, wr_addr, wr_data,
        input  done_rej, z_in, z_valid
    );

    modport slave (
        input  start_rej, rho_out, i_out, j_out, wr_en, wr_addr, wr_data,
        output done_rej, z_in, z_valid
    );
endinterface

// File: rtl/expand_a_collector_addr_gen.sv
// Element (i, j) and coefficient counters, wrap logic and RAM write register.
module expand_a_addr_gen #(
    parameter int K      = 4,
    parameter int L      = 4,
    parameter int N      = 256,
    parameter int COEF_W = 24,
    parameter int ADDR_W = 12,
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              accept,
    input  logic              advance,
    input  logic [COEF_W-1:0] z_in,
    output logic [7:0]        i_q,
    output logic [7:0]        j_q,
    output logic [CNT_W-1:0]  cnt,
    output logic              last_coef,
    output logic              last_elem,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COEF_W-1:0] wr_data
);
    logic [ADDR_W-1:0] addr;

    assign last_coef = (cnt == CNT_W'(N - 1));
    assign last_elem = (i_q == 8'(K - 1)) && (j_q == 8'(L - 1));
    assign addr      = (ADDR_W'(i_q) * ADDR_W'(L) + ADDR_W'(j_q)) * ADDR_W'(N)
                     + ADDR_W'(cnt);

    // Counter update and one-cycle-delayed write of each accepted coefficient.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            i_q     <= '0;
            j_q     <= '0;
            cnt     <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= addr;
                wr_data <= z_in;
            end
            if (clr) begin
                i_q <= '0;
                j_q <= '0;
                cnt <= '0;
            end else if (advance) begin
                cnt <= '0;
                if (last_elem) begin
                    // Park at (0,0) so the counters never leave the matrix.
                    i_q <= '0;
                    j_q <= '0;
                end else if (j_q == 8'(L - 1)) begin
                    j_q <= '0;
                    i_q <= i_q + 8'd1;
                end else begin
                    j_q <= j_q + 8'd1;
                end
            end else if (accept) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/expand_a_collector.sv
// A-matrix expansion controller: sequences one sampler run per (i, j) element
// and stores exactly N coefficients per run.
// Optional: EXPAND_A_RANGE_CHECK_EN adds a z_in >= Q check that sets err.
module expand_a_collector #(
    parameter int K      = dilithium_pkg::K_DEF,
    parameter int L      = dilithium_pkg::L_DEF,
    parameter int N      = dilithium_pkg::N,
    parameter int COEF_W = dilithium_pkg::COEF_W,
    parameter int ADDR_W = 12
`ifdef EXPAND_A_RANGE_CHECK_EN
    , parameter int Q    = dilithium_pkg::Q
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] rho_in,
    output logic         busy,
    output logic         done,
    output logic         err,
    expand_a_collector_if.master bus
);
    import dilithium_pkg::*;

    localparam int CNT_W = $clog2(N + 1);

    state_t           state, state_d;
    logic             busy_d, done_d, err_d, start_rej_q, start_rej_d;
    logic             clr, accept, advance, last_coef, last_elem;
    logic [CNT_W-1:0] cnt;
    logic [255:0]     rho_q;

    expand_a_addr_gen #(
        .K(K), .L(L), .N(N), .COEF_W(COEF_W), .ADDR_W(ADDR_W)
    ) u_addr (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .accept    (accept),
        .advance   (advance),
        .z_in      (bus.z_in),
        .i_q       (bus.i_out),
        .j_q       (bus.j_out),
        .cnt       (cnt),
        .last_coef (last_coef),
        .last_elem (last_elem),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data)
    );

    assign bus.start_rej = start_rej_q;
    assign bus.rho_out   = rho_q;

    // State and registered status outputs; seed captured on accepted start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            start_rej_q <= 1'b0;
            rho_q       <= '0;
        end else begin
            state       <= state_d;
            busy        <= busy_d;
            done        <= done_d;
            err         <= err_d;
            start_rej_q <= start_rej_d;
            if (clr) rho_q <= rho_in;
        end
    end

    // Next state, counter controls and next values of the status outputs.
    always_comb begin
        state_d     = state;
        busy_d      = busy;
        done_d      = 1'b0;
        err_d       = err;
        start_rej_d = 1'b0;
        clr         = 1'b0;
        accept      = 1'b0;
        advance     = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    clr     = 1'b1;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_KICK;
                end
            end
            S_KICK: begin
                start_rej_d = 1'b1;
                state_d     = S_COLLECT;
            end
            S_COLLECT: begin
                accept = bus.z_valid && (cnt < CNT_W'(N));
                if (bus.done_rej) begin
                    // A final coefficient arriving with done_rej completes the run.
                    if (!(accept && last_coef)) err_d = 1'b1;
                    state_d = S_NEXT;
                end else if (accept && last_coef) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (bus.done_rej) state_d = S_NEXT;
            end
            S_NEXT: begin
                advance = 1'b1;
                if (last_elem) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_KICK;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
`ifdef EXPAND_A_RANGE_CHECK_EN
        if (accept && (bus.z_in >= COEF_W'(Q))) err_d = 1'b1;
`endif
    end
endmodule
